barrett_pipe_red: RTL and testbench

// Parametrised, fully pipelined Barrett modular reducer with valid/ready flow control.
// - Accepts one operand x per cycle and returns r = x mod m.
// - Modulus set (m, k, mu) comes from a config port and is held in registers between loads.
// - Carries a user tag through the pipeline, so callers such as the NTT and modmul

---
 rtl/barrett_pipe_red_if.sv | 50 +++++
 rtl/barrett_pipe_red.sv | 153 +++++++++++++++
 tb/tb_barrett_pipe_red.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrett_pipe_red_if.sv
// Purpose: operand, result and modulus-config bundle for barrett_pipe_red.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready handshake; cfg_* has none.
// Ports: cfg_we/cfg_m/cfg_k/cfg_mu  modulus set load
//        in_valid/in_ready/in_x/in_tag  operand stream into the reducer
//        out_valid/out_ready/out_r/out_tag/out_err  result stream out of the reducer
//        idle  no entry in flight and none being accepted this cycle
// Modports: master drives operands/config and consumes results; slave is the reducer.
interface barrett_pipe_red_if #(
  parameter int W     = 32,
  parameter int TAG_W = 4
);
  localparam int KW = $clog2(W) + 1;

  logic               cfg_we;
  logic [W-1:0]       cfg_m;
  logic [KW-1:0]      cfg_k;
  logic [W:0]         cfg_mu;

  logic               in_valid;
  logic               in_ready;
  logic [2*W-1:0]     in_x;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_r;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;

  logic               idle;

  modport master (
    output cfg_we, cfg_m, cfg_k, cfg_mu,
    output in_valid, in_x, in_tag,
    input  in_ready,
    input  out_valid, out_r, out_tag, out_err,
    output out_ready,
    input  idle
  );

  modport slave (
    input  cfg_we, cfg_m, cfg_k, cfg_mu,
    input  in_valid, in_x, in_tag,
    output in_ready,
    output out_valid, out_r, out_tag, out_err,
    input  out_ready,
    output idle
  );
endinterface

// File: rtl/barrett_pipe_red.sv
// Purpose: four-stage pipelined Barrett reducer, r = x mod m, tag carried alongside.
// Latency: result 4 cycles after acceptance, one operand per cycle.
// Backpressure: whole pipe freezes while out_valid & ~out_ready; in_ready = ~stall.
// Ports: clk_i core clock; rst_ni async active-low reset;
//        bus (slave) carries config load, operand stream, result stream and idle.
module barrett_pipe_red #(
  parameter int W     = 32,
  parameter int TAG_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  barrett_pipe_red_if.slave bus
);
  localparam int KW = $clog2(W) + 1;
  // The corrected residue r0 < 3m < 2^(W+2), so W+2 low bits of x and q3*m suffice.
  localparam int RW = W + 2;

  typedef struct packed {
    logic [RW-1:0]    x_lo;
    logic [W:0]       q1;
    logic [TAG_W-1:0] tag;
    logic             err;
  } s1_t;

  typedef struct packed {
    logic [RW-1:0]    x_lo;
    logic [W:0]       q3;
    logic [TAG_W-1:0] tag;
    logic             err;
  } s2_t;

  typedef struct packed {
    logic [RW-1:0]    r0;
    logic [TAG_W-1:0] tag;
    logic             err;
  } s3_t;

  logic [W-1:0]     m_q;
  logic [KW-1:0]    k_q;
  logic [W:0]       mu_q;

  logic             v1_q, v2_q, v3_q, v4_q;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  s3_t              s3_q, s3_d;
  logic [W-1:0]     r_q, r_d;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;

  logic             advance, accept, cfg_load;

  assign advance      = ~(v4_q & ~bus.out_ready);
  assign accept       = bus.in_valid & advance;
  assign bus.in_ready = advance;
  // Counting this cycle's acceptance as busy means a load can never land under
  // an operand, so every entry in flight sees one consistent modulus set.
  assign bus.idle     = ~(v1_q | v2_q | v3_q | v4_q | accept);
  assign cfg_load     = bus.cfg_we & bus.idle;

  logic [KW:0]      two_k;
  logic [KW-1:0]    k_m1, k_p1;
  assign two_k = {k_q, 1'b0};
  assign k_m1  = k_q - KW'(1);
  assign k_p1  = k_q + KW'(1);

  // S1: for in-range x, q1 = x >> (k-1) < 2^(k+1), so W+1 bits hold it.
  always_comb begin
    s1_d      = '0;
    s1_d.x_lo = bus.in_x[RW-1:0];
    s1_d.q1   = (W+1)'(bus.in_x >> k_m1);
    s1_d.tag  = bus.in_tag;
    s1_d.err  = |(bus.in_x >> two_k);
  end

  // S2: q1 < 2^(k+1) and mu <= 2^(k+1) keep the product within 2W+2 bits.
  logic [2*W+1:0] q2;
  assign q2 = (2*W+2)'(s1_q.q1) * (2*W+2)'(mu_q);

  always_comb begin
    s2_d      = '0;
    s2_d.x_lo = s1_q.x_lo;
    s2_d.q3   = (W+1)'(q2 >> k_p1);
    s2_d.tag  = s1_q.tag;
    s2_d.err  = s1_q.err;
  end

  // S3: subtraction is modular in RW bits; only the low bits of q3*m matter.
  logic [RW-1:0] q3m;
  assign q3m = RW'(s2_q.q3) * RW'(m_q);

  always_comb begin
    s3_d     = '0;
    s3_d.r0  = s2_q.x_lo - q3m;
    s3_d.tag = s2_q.tag;
    s3_d.err = s2_q.err;
  end

  // S4: at most two conditional subtractions bring r0 into [0, m).
  logic [RW-1:0] m1, m2;
  assign m1 = RW'(m_q);
  assign m2 = {1'b0, m_q, 1'b0};

  always_comb begin
    r_d = W'(s3_q.r0);
    if (s3_q.r0 >= m2) begin
      r_d = W'(s3_q.r0 - m2);
    end else if (s3_q.r0 >= m1) begin
      r_d = W'(s3_q.r0 - m1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q   <= '0;
      k_q   <= '0;
      mu_q  <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      v4_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      r_q   <= '0;
      tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (cfg_load) begin
        m_q  <= bus.cfg_m;
        k_q  <= bus.cfg_k;
        mu_q <= bus.cfg_mu;
      end
      // Empty slots shift like full ones, so nothing waits behind a bubble.
      if (advance) begin
        v1_q  <= bus.in_valid;
        s1_q  <= s1_d;
        v2_q  <= v1_q;
        s2_q  <= s2_d;
        v3_q  <= v2_q;
        s3_q  <= s3_d;
        v4_q  <= v3_q;
        r_q   <= r_d;
        tag_q <= s3_q.tag;
        err_q <= s3_q.err;
      end
    end
  end

  assign bus.out_valid = v4_q;
  assign bus.out_r     = r_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_barrett_pipe_red.sv
// Purpose: directed and randomised bench for barrett_pipe_red with a result scoreboard.
// Latency: checks the 4-cycle acceptance-to-result latency and 1/cycle throughput.
// Backpressure: drives stalls on out_ready and checks hold/stability and in_ready.
module tb_barrett_pipe_red;
  localparam int W     = 32;
  localparam int TAG_W = 4;

  logic clk    = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  barrett_pipe_red_if #(.W(W), .TAG_W(TAG_W)) bus ();

  barrett_pipe_red #(.W(W), .TAG_W(TAG_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    logic [W-1:0]     r;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               errors = 0;
  int               checks = 0;
  logic [W-1:0]     cur_m  = '0;
  int               cur_k  = 0;
  bit               rand_rdy  = 1'b0;
  bit               fixed_rdy = 1'b1;
  bit               hold_vld  = 1'b0;
  logic [W-1:0]     hold_r;
  logic [TAG_W-1:0] hold_tag;
  logic             hold_err;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] x, input logic [TAG_W-1:0] tag);
    exp_t         e;
    logic [127:0] xx;
    xx    = {64'b0, x};
    e.r   = W'(x % {32'b0, cur_m});
    e.tag = tag;
    e.err = (xx >> (2 * cur_k)) != 0;
    return e;
  endfunction

  // out_ready is owned by this process; it settles 2 time units after each edge.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
  end

  // Scoreboard pop and stall-stability monitor.
  always @(negedge clk) begin
    if (!rst_ni) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("stall_valid_held", bus.out_valid, 1);
        chk("stall_r_stable", bus.out_r, hold_r);
        chk("stall_tag_stable", bus.out_tag, hold_tag);
        chk("stall_err_stable", bus.out_err, hold_err);
      end
      hold_vld = bus.out_valid && !bus.out_ready;
      hold_r   = bus.out_r;
      hold_tag = bus.out_tag;
      hold_err = bus.out_err;
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_tag", bus.out_tag, mon_e.tag);
          chk("sb_err", bus.out_err, mon_e.err);
          if (!mon_e.err) chk("sb_r", bus.out_r, mon_e.r);
        end
      end
    end
  end

  task automatic send(input logic [63:0] x, input logic [TAG_W-1:0] tag);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_tag   = tag;
    for (int i = 0; i < 1000 && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        sb.push_back(model(x, tag));
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", acc, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.idle) done = 1'b1;
    end
    chk("drain_empty", sb.size(), 0);
    chk("drain_idle", bus.idle, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [W-1:0] m);
    int           k;
    logic [127:0] mu;
    k = 0;
    while ((64'(m) >> k) != 0) k++;
    mu = (128'd1 << (2 * k)) / {96'b0, m};
    bus.cfg_we = 1'b1;
    bus.cfg_m  = m;
    bus.cfg_k  = 6'(k);
    bus.cfg_mu = 33'(mu);
    @(negedge clk);
    chk("cfg_while_idle", bus.idle, 1);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    cur_m      = m;
    cur_k      = k;
  endtask

  // Call right after send() returns: result must show on the 4th cycle, not before.
  task automatic expect_lat(input string name, input logic [W-1:0] r,
                            input logic [TAG_W-1:0] tag, input logic err, input bit chk_r);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({name, "_early_valid"}, bus.out_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_tag"}, bus.out_tag, tag);
    chk({name, "_err"}, bus.out_err, err);
    if (chk_r) chk({name, "_r"}, bus.out_r, r);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_phase(input int n);
    logic [127:0]     mask;
    logic [63:0]      x;
    logic [TAG_W-1:0] tag;
    tag      = '0;
    mask     = (128'd1 << (2 * cur_k)) - 1;
    rand_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      x = {$urandom, $urandom} & mask[63:0];
      send(x, tag);
      tag = tag + 1'b1;
    end
    rand_rdy = 1'b0;
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0]     t2_exp [4];
    logic [W-1:0]     rnd_m;
    int               kk;
    t2_exp = '{32'd0, 32'd0, 32'd3, 32'd16};

    bus.cfg_we   = 1'b0;
    bus.cfg_m    = '0;
    bus.cfg_k    = '0;
    bus.cfg_mu   = '0;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_tag   = '0;

    // Reset state
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_r", bus.out_r, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_idle", bus.idle, 1);
    #20 rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // 1: single operand, exact latency
    load_cfg(32'd17);
    send(64'd288, 4'd3);
    expect_lat("t1", 32'd16, 4'd3, 1'b0, 1'b1);
    drain();

    // 2: back-to-back results on consecutive cycles, in order
    send(64'd0, 4'd4);
    send(64'd289, 4'd5);
    send(64'd1023, 4'd6);
    send(64'd16, 4'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_valid_seq", bus.out_valid, 1);
      chk("t2_tag_seq", bus.out_tag, 4 + i);
      chk("t2_r_seq", bus.out_r, t2_exp[i]);
      @(posedge clk);
      #1;
    end
    drain();

    // 3: x = 2^(2k) flags a range error but still flows
    send(64'd1024, 4'd8);
    expect_lat("t3", 32'd0, 4'd8, 1'b1, 1'b0);
    drain();

    // 4: five-cycle stall with four in flight
    fixed_rdy = 1'b0;
    send(64'd100, 4'd9);
    send(64'd200, 4'd10);
    send(64'd300, 4'd11);
    send(64'd400, 4'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready_low", bus.in_ready, 0);
      chk("t4_out_valid", bus.out_valid, 1);
      chk("t4_head_tag", bus.out_tag, 9);
      chk("t4_head_r", bus.out_r, 32'd15);
      @(posedge clk);
      #1;
    end
    fixed_rdy = 1'b1;
    drain();

    // 5: config load while busy is dropped; reload after idle takes effect
    send(64'd288, 4'd13);
    bus.cfg_we = 1'b1;
    bus.cfg_m  = 32'd3329;
    bus.cfg_k  = 6'd12;
    bus.cfg_mu = 33'd5039;
    @(negedge clk);
    chk("t5_busy_not_idle", bus.idle, 0);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    drain();
    send(64'd288, 4'd14);
    expect_lat("t5_old_cfg", 32'd16, 4'd14, 1'b0, 1'b1);
    drain();
    load_cfg(32'd3329);
    send(64'd11095561, 4'd15);
    expect_lat("t5_new_cfg", 32'd4, 4'd15, 1'b0, 1'b1);
    drain();

    // 6: asynchronous reset with operands in flight
    send(64'd1, 4'd1);
    send(64'd2, 4'd2);
    send(64'd3, 4'd3);
    @(posedge clk);
    #3;
    chk("t6_pre_rst_valid", bus.out_valid, 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_idle", bus.idle, 1);
    chk("t6_rst_in_ready", bus.in_ready, 1);
    chk("t6_rst_out_r", bus.out_r, 0);
    chk("t6_rst_out_tag", bus.out_tag, 0);
    chk("t6_rst_out_err", bus.out_err, 0);
    sb.delete();
    @(posedge clk);
    #3 rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_stale_valid", bus.out_valid, 0);
      chk("t6_post_idle", bus.idle, 1);
      @(posedge clk);
    end
    #1;

    // 7: random operands and random backpressure
    load_cfg(32'hFFFF_FFFB);
    rand_phase(5000);
    kk    = $urandom_range(2, 31);
    rnd_m = (32'd1 << (kk - 1)) | ($urandom & ((32'd1 << (kk - 1)) - 1));
    load_cfg(rnd_m);
    rand_phase(5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
